// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard status from the pipeline stages and sequencing controls back to them.
interface pipe_hazard_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_is_ld;
    logic [REG_W-1:0] ex_rd;
    logic             ex_br_taken;
    logic             ma_mem_req;
    logic             ma_mem_ready;
    logic             rw_is_halt;
    logic             en_pc;
    logic             en_if_of;
    logic             en_of_ex;
    logic             en_ex_ma;
    logic             en_ma_rw;
    logic             flush_if_of;
    logic             flush_of_ex;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_ld, ex_rd, ex_br_taken,
               ma_mem_req, ma_mem_ready, rw_is_halt,
        input  en_pc, en_if_of, en_of_ex, en_ex_ma, en_ma_rw, flush_if_of, flush_of_ex,
               halted, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_ld, ex_rd, ex_br_taken,
               ma_mem_req, ma_mem_ready, rw_is_halt,
        output en_pc, en_if_of, en_of_ex, en_ex_ma, en_ma_rw, flush_if_of, flush_of_ex,
               halted, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: latch enables/flushes for a 5-stage pipeline; load-use, branch, memory wait, halt.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst,
    pipe_hazard_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t           state, nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt, stall_cnt;
    logic [REG_W-1:0] rd;
    logic             hazard, to_nxt, halted_q, timeout_q;
    logic [6:0]       go_ctl, ctl;

    assign rd     = bus.ex_rd;
    assign hazard = bus.ex_is_ld && ((bus.id_use_rs1 && bus.id_rs1 == rd) ||
                                     (bus.id_use_rs2 && bus.id_rs2 == rd));
    // {pc, if_of, of_ex, ex_ma, ma_rw, flush_if_of, flush_of_ex}; branch squashes any load-use stall
    assign go_ctl = bus.ex_br_taken ? 7'b11111_11 : hazard ? 7'b00111_01 : 7'b11111_00;

    always_comb begin
        nxt      = state;
        wait_nxt = wait_cnt;
        to_nxt   = 1'b0;
        ctl      = '0;
        case (state)
            RUN: begin
                if (bus.ma_mem_req && !bus.ma_mem_ready) begin
                    nxt      = MEM_WAIT;
                    wait_nxt = CNT_W'(1);
                end else begin
                    ctl = go_ctl;
                    nxt = bus.rw_is_halt ? HALT : RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.ma_mem_ready) begin
                    ctl      = go_ctl;
                    nxt      = RUN;
                    wait_nxt = '0;
                end else begin
                    wait_nxt = wait_cnt + CNT_W'(1);
                    to_nxt   = wait_cnt == CNT_W'(MEM_TIMEOUT);
                    nxt      = to_nxt ? HALT : MEM_WAIT;
                end
            end
            default: ;
        endcase
        ctl = rst ? 7'b0 : ctl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= nxt;
            wait_cnt  <= wait_nxt;
            halted_q  <= nxt == HALT;
            timeout_q <= timeout_q | to_nxt;
            if (!ctl[6] && state != HALT && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign {bus.en_pc, bus.en_if_of, bus.en_of_ex, bus.en_ex_ma, bus.en_ma_rw,
            bus.flush_if_of, bus.flush_of_ex} = ctl;
    assign bus.halted       = halted_q;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_cnt;
endmodule
